// File: rtl/demux_pkg.sv
// Shared constants for the 2:1 2-bit mux/demux path.
// Lane ids, default sizing and a ceil-log2 helper for pointer widths.
package demux_pkg;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

    localparam int DEF_WIDTH = 2;
    localparam int DEF_DEPTH = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/demux_lane_fifo.sv
// Per-lane FIFO with registered head and occupancy count.
// Ports: clk_i, rst_i (async, high), push_i, pop_i, data_i,
//        data_o (0 when empty), empty_o, full_o, count_o (0..DEPTH).
module demux_lane_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [WIDTH-1:0]   data_i,
    output logic [WIDTH-1:0]   data_o,
    output logic               empty_o,
    output logic               full_o,
    output logic [clog2(DEPTH):0] count_o
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign count_o = cnt_q;

    // Guard here as well so a stray pop/push never corrupts the count.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Head reads 0 while empty, even after slots have been drained.
    assign data_o = empty_o ? '0 : mem_q[rd_q];

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + AW'(1);
        if (do_pop)  rd_d = rd_q + AW'(1);
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (do_push) mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/demux1_2_2bits_fifo.sv
// 1:2 demux splitting one word stream into two buffered lanes.
// Ports: clk, reset, data_in/valid_in/selector/ready_in upstream;
//        data_outX/valid_outX/ready_outX per lane; sticky overflow.
module demux1_2_2bits_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter bit AUTO_ALT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    input  logic             selector,
    output logic             ready_in,
    output logic [WIDTH-1:0] data_out0,
    output logic             valid_out0,
    input  logic             ready_out0,
    output logic [WIDTH-1:0] data_out1,
    output logic             valid_out1,
    input  logic             ready_out1,
    output logic             overflow
);

    logic alt_q, alt_d;
    logic ovf_q, ovf_d;
    logic tgt;
    logic push;
    logic empty0, empty1;
    logic full0, full1;
    logic [clog2(DEPTH):0] cnt0_unused;
    logic [clog2(DEPTH):0] cnt1_unused;

    assign tgt      = AUTO_ALT ? alt_q : selector;
    assign ready_in = (tgt == LANE1) ? !full1 : !full0;
    assign push     = valid_in && ready_in;

    assign valid_out0 = !empty0;
    assign valid_out1 = !empty1;
    assign overflow   = ovf_q;

    // Alternation only advances on an accepted word.
    always_comb begin
        alt_d = alt_q ^ push;
        ovf_d = ovf_q | (valid_in & ~ready_in);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alt_q <= LANE0;
            ovf_q <= 1'b0;
        end else begin
            alt_q <= alt_d;
            ovf_q <= ovf_d;
        end
    end

    demux_lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane0 (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (push && (tgt == LANE0)),
        .pop_i   (ready_out0),
        .data_i  (data_in),
        .data_o  (data_out0),
        .empty_o (empty0),
        .full_o  (full0),
        .count_o (cnt0_unused)
    );

    demux_lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane1 (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (push && (tgt == LANE1)),
        .pop_i   (ready_out1),
        .data_i  (data_in),
        .data_o  (data_out1),
        .empty_o (empty1),
        .full_o  (full1),
        .count_o (cnt1_unused)
    );

endmodule

// File: tb/tb_demux1_2_2bits_fifo.sv
// Scoreboard bench: dut 0 steered by selector, dut 1 auto-alternating.
// Expected words queue per lane; a negedge monitor pops and compares.
module tb_demux1_2_2bits_fifo;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] din  [2];
    logic       vin  [2];
    logic       sel  [2];
    logic       rdy  [2];
    logic [1:0] dout0[2];
    logic       vout0[2];
    logic       rout0[2];
    logic [1:0] dout1[2];
    logic       vout1[2];
    logic       rout1[2];
    logic       ovf  [2];

    int n_vec = 0;
    int n_err = 0;

    // Reference: per dut, per lane, ordered list of words not yet consumed.
    logic [1:0] mq [2][2][$];
    bit         alt_m = 1'b0;
    bit         ovf_m [2];

    always #5 clk = ~clk;

    demux1_2_2bits_fifo #(.WIDTH(2), .DEPTH(DEPTH), .AUTO_ALT(1'b0)) u_man (
        .clk(clk), .reset(reset),
        .data_in(din[0]), .valid_in(vin[0]), .selector(sel[0]),
        .ready_in(rdy[0]),
        .data_out0(dout0[0]), .valid_out0(vout0[0]), .ready_out0(rout0[0]),
        .data_out1(dout1[0]), .valid_out1(vout1[0]), .ready_out1(rout1[0]),
        .overflow(ovf[0])
    );

    demux1_2_2bits_fifo #(.WIDTH(2), .DEPTH(DEPTH), .AUTO_ALT(1'b1)) u_alt (
        .clk(clk), .reset(reset),
        .data_in(din[1]), .valid_in(vin[1]), .selector(sel[1]),
        .ready_in(rdy[1]),
        .data_out0(dout0[1]), .valid_out0(vout0[1]), .ready_out0(rout0[1]),
        .data_out1(dout1[1]), .valid_out1(vout1[1]), .ready_out1(rout1[1]),
        .overflow(ovf[1])
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h",
                     name, $time, act, exp);
        end
    endtask

    task automatic lane_mon(input int d, input int l, input logic v,
                            input logic [1:0] dat, input logic r);
        bit ev;
        ev = (mq[d][l].size() != 0);
        chk($sformatf("dut%0d valid_out%0d", d, l), 32'(v), 32'(ev));
        if (ev) begin
            chk($sformatf("dut%0d data_out%0d", d, l), 32'(dat),
                32'(mq[d][l][0]));
            if (r) void'(mq[d][l].pop_front());
        end else begin
            chk($sformatf("dut%0d data_out%0d empty", d, l), 32'(dat), 0);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            lane_mon(d, 0, vout0[d], dout0[d], rout0[d]);
            lane_mon(d, 1, vout1[d], dout1[d], rout1[d]);
        end
    end

    task automatic drv(input int d, input bit v, input bit s,
                       input logic [1:0] x, input bit r0, input bit r1);
        vin[d]   = v;
        sel[d]   = s;
        din[d]   = x;
        rout0[d] = r0;
        rout1[d] = r1;
    endtask

    task automatic idle();
        drv(0, 0, 0, 2'b00, 0, 0);
        drv(1, 0, 0, 2'b00, 0, 0);
    endtask

    // Called at posedge+1 with inputs already applied; returns at next
    // posedge+1 after committing the accepted words to the model.
    task automatic step();
        int tg[2];
        bit er[2];
        tg[0] = int'(sel[0]);
        tg[1] = int'(alt_m);
        for (int d = 0; d < 2; d++) er[d] = (mq[d][tg[d]].size() < DEPTH);
        #3;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d ready_in", d), 32'(rdy[d]), 32'(er[d]));
            chk($sformatf("dut%0d overflow", d), 32'(ovf[d]), 32'(ovf_m[d]));
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (vin[d]) begin
                if (er[d]) begin
                    mq[d][tg[d]].push_back(din[d]);
                    if (d == 1) alt_m = ~alt_m;
                end else begin
                    ovf_m[d] = 1'b1;
                end
            end
        end
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d rst valid_out0", d), 32'(vout0[d]), 0);
            chk($sformatf("dut%0d rst valid_out1", d), 32'(vout1[d]), 0);
            chk($sformatf("dut%0d rst data_out0", d), 32'(dout0[d]), 0);
            chk($sformatf("dut%0d rst data_out1", d), 32'(dout1[d]), 0);
            chk($sformatf("dut%0d rst ready_in", d), 32'(rdy[d]), 1);
            chk($sformatf("dut%0d rst overflow", d), 32'(ovf[d]), 0);
            for (int l = 0; l < 2; l++) mq[d][l].delete();
            ovf_m[d] = 1'b0;
        end
        alt_m = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain();
        drv(0, 0, 0, 2'b00, 1, 1);
        drv(1, 0, 0, 2'b00, 1, 1);
        repeat (DEPTH + 2) step();
        idle();
    endtask

    initial begin
        logic [1:0] fill [4];
        fill[0] = 2'd3; fill[1] = 2'd2; fill[2] = 2'd1; fill[3] = 2'd0;
        idle();
        @(posedge clk);
        #1;
        do_reset();

        // Reset mid-stream: two words parked in lane 0, then reset.
        drv(0, 1, 0, 2'b10, 0, 0); step();
        drv(0, 1, 0, 2'b11, 0, 0); step();
        idle(); step();
        do_reset();

        // Manual steering with both consumers ready.
        drv(0, 1, 0, 2'b01, 1, 1); step();
        drv(0, 1, 1, 2'b10, 1, 1); step();
        drain();

        // Auto alternation into stalled lanes, then ordered pops.
        for (int i = 0; i < 4; i++) begin
            drv(1, 1, 0, 2'(i), 0, 0);
            step();
        end
        idle(); step();
        drain();

        // Full lane 0, rejected fifth word, lane 1 still accepts.
        for (int i = 0; i < 4; i++) begin
            drv(0, 1, 0, fill[i], 0, 0);
            step();
        end
        drv(0, 1, 0, 2'b11, 0, 0); step();
        idle(); step();
        drv(0, 1, 1, 2'b01, 0, 0); step();
        idle(); step();
        drain();
        do_reset();

        // Push and pop together on lane 1 holding two words.
        drv(0, 1, 1, 2'b00, 0, 0); step();
        drv(0, 1, 1, 2'b01, 0, 0); step();
        for (int i = 0; i < 6; i++) begin
            drv(0, 1, 1, 2'(i + 2), 0, 1);
            step();
        end
        drv(0, 1, 1, 2'b11, 0, 0); step();
        drv(0, 1, 1, 2'b10, 0, 0); step();
        drv(0, 1, 1, 2'b01, 0, 0); step();
        drain();

        // Rejected word must not advance alternation.
        for (int i = 0; i < 8; i++) begin
            drv(1, 1, 0, 2'(i), 0, 0);
            step();
        end
        drv(1, 1, 0, 2'b11, 0, 0); step();
        drv(1, 0, 0, 2'b00, 1, 0); step();
        drv(1, 1, 1, 2'b10, 0, 0); step();
        idle(); step();
        drain();
        do_reset();

        // Randomized traffic on both duts with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            for (int d = 0; d < 2; d++) begin
                drv(d, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 2) == 0));
            end
            step();
            if (i % 500 == 499) do_reset();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/demux1_2_2bits_fifo.md
Name: demux1_2_2bits_fifo

Overview:
- Receiving end of the 2:1 2-bit mux path: takes one 2-bit word stream and routes each accepted word to one of two output lanes.
- Each lane is buffered in its own small FIFO with a valid/ready handshake.
- Sits after the registered mux, so a stream interleaved by the mux is split back into its two sources.
- Lane choice comes from an external selector, or from an internal toggle in auto mode.

Parameters:
- WIDTH, 2, data word width in bits.
- DEPTH, 4, per-lane FIFO depth in words; power of two, minimum 2.
- AUTO_ALT, 0, 1 = internal alternating lane select and selector is ignored; 0 = selector input chooses the lane.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  WIDTH  input word.
- valid_in  input  1  data_in is valid this cycle.
- selector  input  1  target lane when AUTO_ALT=0: 0 = lane 0, 1 = lane 1.
- ready_in  output  1  target lane can accept a word.
- data_out0  output  WIDTH  lane 0 FIFO head.
- valid_out0  output  1  lane 0 not empty.
- ready_out0  input  1  lane 0 consumer pops the head.
- data_out1  output  WIDTH  lane 1 FIFO head.
- valid_out1  output  1  lane 1 not empty.
- ready_out1  input  1  lane 1 consumer pops the head.
- overflow  output  1  sticky; set when valid_in=1 while ready_in=0.

Behaviour:
- Reset is asynchronous and active-high.
  - Clears both FIFO pointers and counts, the alternate-select flop (lane 0 next) and overflow.
  - Outputs while reset=1 and immediately after: valid_out0=valid_out1=0, data_out0=data_out1=0, overflow=0, ready_in=1.
  - FIFO storage is also cleared, so data_out0/data_out1 read 0 while a lane is empty.
- Target lane:
  - AUTO_ALT=0: tgt = selector.
  - AUTO_ALT=1: tgt = alt flop.
- ready_in = NOT full(tgt). Combinational from tgt and the registered counts.
- Push occurs when valid_in AND ready_in; it writes data_in into the tgt FIFO at the clock edge.
- Alt flop toggles only on a push. Rejected or idle cycles do not advance it.
- Latency: a word pushed at edge N appears on data_outX with valid_outX=1 after edge N (visible in cycle N+1). No combinational input-to-output path.
- Pop occurs when valid_outX AND ready_outX.
  - Advances the read pointer at the edge.
  - The next head is visible in the following cycle.
  - ready_outX while empty is ignored.
- Simultaneous push and pop on the same lane:
  - Count is unchanged; both pointers advance.
  - Allowed at any fill level except full, where ready_in=0 blocks the push (no pass-through when full).
- Full condition: count == DEPTH. ready_in drops only when the selected lane is full, so the other lane still accepts.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Overflow:
  - Set on any cycle with valid_in=1 and ready_in=0.
  - The word is dropped and the alt flop does not toggle.
  - Cleared only by reset.
- Reset mid-operation discards all buffered words. valid_out0 and valid_out1 fall asynchronously with reset.
- Lanes are fully independent: a stall on one lane does not affect pops on the other.

Decomposition:
- Shared package demux_pkg holds:
  - LANE0=1'b0, LANE1=1'b1;
  - a function clog2 for pointer widths;
  - default WIDTH/DEPTH constants shared with the mux-side tester.
- Sub-module demux_lane_fifo (WIDTH, DEPTH) provides: push, pop, data_in, data_out, empty, full, count. It is instantiated twice.
- The top holds tgt/alt selection, ready_in, push steering and overflow.

Test Plan:
- Reset assert mid-stream, AUTO_ALT=0:
  - Load lane 0 with 2 words, assert reset for 1 cycle.
  - Expect valid_out0=0 and data_out0=0 at once, overflow=0, ready_in=1.
- Manual steering, AUTO_ALT=0, both ready_out=1:
  - Drive selector=0 with data 2'b01, then selector=1 with 2'b10.
  - Expect data_out0=2'b01 one cycle after its push and data_out1=2'b10 one cycle after its push.
- Auto alternate, AUTO_ALT=1:
  - Push 2'b00, 2'b01, 2'b10, 2'b11 back-to-back with ready_out0=ready_out1=0.
  - Expect lane 0 to hold 00,10 and lane 1 to hold 01,11.
  - Then pop both lanes in order and check that order.
- Full and backpressure, AUTO_ALT=0:
  - With selector=0 and ready_out0=0, push 4 words (3,2,1,0); expect ready_in=0 afterwards.
  - A 5th valid_in sets overflow=1; lane 0 still holds 3,2,1,0.
  - Switch selector=1: expect ready_in=1 and lane 1 accepts.
- Simultaneous push/pop at count=2 on lane 1:
  - Expect count to stay 2 and output order preserved across pointer wrap after 6 such cycles.
- Rejected word does not toggle alternation, AUTO_ALT=1:
  - Fill lane 0, then present a word that targets the full lane 0; expect it rejected and overflow=1.
  - Pop one word from lane 0; the next push goes to lane 0, not lane 1.
